proc_perf_cnt: RTL and testbench

PROC_PERF_CNT -- requirements
Module: proc_perf_cnt

---
 rtl/proc_perf_cnt.sv | 86 ++++++++
 tb/tb_proc_perf_cnt.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_perf_cnt.sv
// Processor performance counter block: eight saturating event counters with
// a one-cycle registered read port and a halt-freeze state machine.
module proc_perf_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             RegWrite,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic             Halt,
  input  logic             ICacheReq,
  input  logic             ICacheHit,
  input  logic             DCacheReq,
  input  logic             DCacheHit,
  input  logic             rd_req,
  input  logic [2:0]       rd_sel,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             halted,
  output logic [7:0]       sat,
  output logic             proto_err
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } stateT;

  localparam logic [WIDTH-1:0] CountMax = '1;

  stateT            state;
  logic [WIDTH-1:0] counters [8];
  logic [7:0]       countEn;
  logic             hitErr;

  // Per-counter increment requests, indexed exactly like rd_sel.
  always_comb begin
    countEn    = '0;
    countEn[0] = 1'b1;
    countEn[1] = Halt | RegWrite | MemWrite;
    countEn[2] = ICacheReq;
    countEn[3] = ICacheReq & ICacheHit;
    countEn[4] = DCacheReq;
    countEn[5] = DCacheReq & DCacheHit;
    countEn[6] = MemRead;
    countEn[7] = MemWrite;
    hitErr     = (ICacheHit & ~ICacheReq) | (DCacheHit & ~DCacheReq);
  end

  // The read port samples before this edge's increments, so a read issued
  // alongside clr or an event still returns the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      sat       <= '0;
      proto_err <= 1'b0;
      for (int i = 0; i < 8; i++) counters[i] <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= counters[rd_sel];

      if (clr) begin
        state     <= RUN;
        sat       <= '0;
        proto_err <= 1'b0;
        for (int i = 0; i < 8; i++) counters[i] <= '0;
      end else if (state == RUN) begin
        for (int i = 0; i < 8; i++) begin
          if (countEn[i] && counters[i] != CountMax) begin
            counters[i] <= counters[i] + WIDTH'(1);
            if (counters[i] == CountMax - WIDTH'(1)) sat[i] <= 1'b1;
          end
        end
        if (hitErr) proto_err <= 1'b1;
        if (Halt) state <= HALTED;
      end
    end
  end

  assign halted = (state == HALTED);

endmodule

// File: tb/tb_proc_perf_cnt.sv
// Self-checking bench for proc_perf_cnt: directed vector tables, corner-case
// sequences and randomized traffic against a saturating-arithmetic model.
module tb_proc_perf_cnt;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  localparam logic [7:0] EvRw  = 8'h01;
  localparam logic [7:0] EvMw  = 8'h02;
  localparam logic [7:0] EvMr  = 8'h04;
  localparam logic [7:0] EvHl  = 8'h08;
  localparam logic [7:0] EvIrq = 8'h10;
  localparam logic [7:0] EvIht = 8'h20;
  localparam logic [7:0] EvDrq = 8'h40;
  localparam logic [7:0] EvDht = 8'h80;

  typedef struct {
    logic       rst;
    logic       clr;
    logic [7:0] ev;
    logic       rdReq;
    logic [2:0] rdSel;
  } stimT;

  typedef struct {
    stimT       s;
    logic       expValid;
    logic [W-1:0] expData;
    logic       expHalted;
  } vecT;

  logic clk = 1'b0;
  logic rst, clr, RegWrite, MemWrite, MemRead, Halt;
  logic ICacheReq, ICacheHit, DCacheReq, DCacheHit;
  logic rd_req;
  logic [2:0] rd_sel;
  logic rd_valid;
  logic [W-1:0] rd_data;
  logic halted;
  logic [7:0] sat;
  logic proto_err;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state: plain integer counts clipped at the maximum.
  int mCount [8];
  bit mHalted, mProto, mValid;
  int mData;

  always #5 clk = ~clk;

  proc_perf_cnt #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead), .Halt(Halt),
    .ICacheReq(ICacheReq), .ICacheHit(ICacheHit),
    .DCacheReq(DCacheReq), .DCacheHit(DCacheHit),
    .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .halted(halted),
    .sat(sat), .proto_err(proto_err)
  );

  function automatic stimT mk(logic r, logic c, logic [7:0] e, logic rq, logic [2:0] sel);
    stimT s;
    s.rst = r; s.clr = c; s.ev = e; s.rdReq = rq; s.rdSel = sel;
    return s;
  endfunction

  function automatic vecT mkVec(stimT s, logic v, int d, logic h);
    vecT x;
    x.s = s; x.expValid = v; x.expData = W'(d); x.expHalted = h;
    return x;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 8; i++) mCount[i] = 0;
    mHalted = 0; mProto = 0;
  endfunction

  // One clock edge of the specified behaviour, computed from event rules.
  function automatic void modelStep(stimT s);
    bit evHit [8];
    if (s.rst) begin
      modelReset();
      mValid = 0; mData = 0;
      return;
    end
    mValid = s.rdReq;
    if (s.rdReq) mData = mCount[s.rdSel];
    if (s.clr) begin
      modelReset();
      return;
    end
    if (mHalted) return;
    evHit[0] = 1;
    evHit[1] = s.ev[3] | s.ev[0] | s.ev[1];
    evHit[2] = s.ev[4];
    evHit[3] = s.ev[4] & s.ev[5];
    evHit[4] = s.ev[6];
    evHit[5] = s.ev[6] & s.ev[7];
    evHit[6] = s.ev[2];
    evHit[7] = s.ev[1];
    for (int i = 0; i < 8; i++)
      if (evHit[i] && mCount[i] < MAXV) mCount[i] = mCount[i] + 1;
    if ((s.ev[5] && !s.ev[4]) || (s.ev[7] && !s.ev[6])) mProto = 1;
    if (s.ev[3]) mHalted = 1;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] expSat;
    for (int i = 0; i < 8; i++) expSat[i] = (mCount[i] == MAXV);
    checkVal({tag, " rd_valid"}, 32'(rd_valid), 32'(mValid));
    checkVal({tag, " rd_data"}, 32'(rd_data), 32'(mData));
    checkVal({tag, " halted"}, 32'(halted), 32'(mHalted));
    checkVal({tag, " sat"}, 32'(sat), 32'(expSat));
    checkVal({tag, " proto_err"}, 32'(proto_err), 32'(mProto));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare to the model.
  task automatic applyStimulus(input stimT s, input string tag);
    rst = s.rst; clr = s.clr;
    RegWrite = s.ev[0]; MemWrite = s.ev[1]; MemRead = s.ev[2]; Halt = s.ev[3];
    ICacheReq = s.ev[4]; ICacheHit = s.ev[5]; DCacheReq = s.ev[6]; DCacheHit = s.ev[7];
    rd_req = s.rdReq; rd_sel = s.rdSel;
    @(posedge clk);
    modelStep(s);
    #1;
    checkOutput(tag);
  endtask

  task automatic applyVec(input vecT v, input string tag);
    applyStimulus(v.s, tag);
    checkVal({tag, " vec rd_valid"}, 32'(rd_valid), 32'(v.expValid));
    checkVal({tag, " vec rd_data"}, 32'(rd_data), 32'(v.expData));
    checkVal({tag, " vec halted"}, 32'(halted), 32'(v.expHalted));
  endtask

  vecT tblA [$];
  vecT tblB [$];

  initial begin
    stimT s;
    rst = 1; clr = 0; RegWrite = 0; MemWrite = 0; MemRead = 0; Halt = 0;
    ICacheReq = 0; ICacheHit = 0; DCacheReq = 0; DCacheHit = 0;
    rd_req = 0; rd_sel = 0;
    modelReset(); mValid = 0; mData = 0;

    // Reset, idle count, read of cycles, then the retire/halt scenario.
    tblA.push_back(mkVec(mk(1, 0, 8'h00, 0, 0), 0, 0, 0));
    tblA.push_back(mkVec(mk(1, 0, 8'h00, 0, 0), 0, 0, 0));
    for (int i = 0; i < 10; i++) tblA.push_back(mkVec(mk(0, 0, 8'h00, 0, 0), 0, 0, 0));
    tblA.push_back(mkVec(mk(0, 0, 8'h00, 1, 0), 1, 10, 0));
    tblA.push_back(mkVec(mk(0, 0, 8'h00, 0, 0), 0, 10, 0));
    tblA.push_back(mkVec(mk(0, 1, 8'h00, 0, 0), 0, 10, 0));
    tblA.push_back(mkVec(mk(0, 0, EvRw, 0, 0), 0, 10, 0));
    tblA.push_back(mkVec(mk(0, 0, EvRw, 0, 0), 0, 10, 0));
    tblA.push_back(mkVec(mk(0, 0, EvRw | EvMw, 0, 0), 0, 10, 0));
    tblA.push_back(mkVec(mk(0, 0, EvMw, 0, 0), 0, 10, 0));
    tblA.push_back(mkVec(mk(0, 0, EvMr, 0, 0), 0, 10, 0));
    tblA.push_back(mkVec(mk(0, 0, EvHl, 0, 0), 0, 10, 1));

    tblB.push_back(mkVec(mk(0, 0, 8'h00, 1, 1), 1, 5, 1));
    tblB.push_back(mkVec(mk(0, 0, 8'h00, 1, 7), 1, 2, 1));
    tblB.push_back(mkVec(mk(0, 0, 8'h00, 1, 6), 1, 1, 1));
    tblB.push_back(mkVec(mk(0, 0, 8'h00, 1, 0), 1, 6, 1));
    tblB.push_back(mkVec(mk(0, 0, 8'h00, 0, 0), 0, 6, 1));

    #1;
    foreach (tblA[i]) applyVec(tblA[i], "tblA");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(mk(0, 0, 8'($urandom) | EvHl, 0, 0), "frozen");
      checkVal("frozen halted", 32'(halted), 32'd1);
    end
    foreach (tblB[i]) applyVec(tblB[i], "tblB");

    // Cache hits with and without a matching request.
    applyStimulus(mk(0, 1, 8'h00, 0, 0), "icache");
    for (int i = 0; i < 3; i++) applyStimulus(mk(0, 0, EvIrq | EvIht, 0, 0), "icache");
    applyStimulus(mk(0, 0, EvIrq, 0, 0), "icache");
    applyStimulus(mk(0, 0, EvIht, 0, 0), "icache");
    applyStimulus(mk(0, 0, 8'h00, 1, 2), "icache");
    checkVal("icache_req", 32'(rd_data), 32'd4);
    applyStimulus(mk(0, 0, 8'h00, 1, 3), "icache");
    checkVal("icache_hit", 32'(rd_data), 32'd3);
    checkVal("proto_err sticky", 32'(proto_err), 32'd1);

    // Saturation at the counter maximum, then clear.
    applyStimulus(mk(0, 1, 8'h00, 0, 0), "satur");
    checkVal("proto_err cleared", 32'(proto_err), 32'd0);
    for (int i = 0; i < 20; i++) applyStimulus(mk(0, 0, EvDrq, 0, 0), "satur");
    applyStimulus(mk(0, 0, 8'h00, 1, 4), "satur");
    checkVal("dcache_req saturated", 32'(rd_data), 32'd15);
    checkVal("sat[4]", 32'(sat[4]), 32'd1);
    applyStimulus(mk(0, 1, 8'h00, 0, 0), "satur");
    checkVal("sat after clr", 32'(sat), 32'd0);
    applyStimulus(mk(0, 0, 8'h00, 1, 4), "satur");
    checkVal("dcache_req after clr", 32'(rd_data), 32'd0);

    // Read in the same cycle as an increment returns the older value.
    applyStimulus(mk(0, 1, 8'h00, 0, 0), "rdcoll");
    for (int i = 0; i < 7; i++) applyStimulus(mk(0, 0, EvRw, 0, 0), "rdcoll");
    applyStimulus(mk(0, 0, EvRw, 1, 1), "rdcoll");
    checkVal("inst pre-increment", 32'(rd_data), 32'd7);
    applyStimulus(mk(0, 0, 8'h00, 1, 1), "rdcoll");
    checkVal("inst post-increment", 32'(rd_data), 32'd8);

    // clr beats Halt; rst in HALTED with a read in flight.
    applyStimulus(mk(0, 1, EvHl, 0, 0), "clrhalt");
    checkVal("halted after clr+Halt", 32'(halted), 32'd0);
    applyStimulus(mk(0, 0, 8'h00, 1, 1), "clrhalt");
    checkVal("inst after clr+Halt", 32'(rd_data), 32'd0);
    applyStimulus(mk(0, 0, EvHl, 0, 0), "clrhalt");
    checkVal("halted after Halt", 32'(halted), 32'd1);
    applyStimulus(mk(1, 0, 8'h00, 1, 1), "clrhalt");
    checkVal("rd_valid suppressed by rst", 32'(rd_valid), 32'd0);
    checkVal("halted after rst", 32'(halted), 32'd0);
    applyStimulus(mk(0, 0, 8'h00, 1, 1), "clrhalt");
    checkVal("inst after rst", 32'(rd_data), 32'd0);
    applyStimulus(mk(0, 0, 8'h00, 1, 0), "clrhalt");
    checkVal("first counted cycle", 32'(rd_data), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      s.rst   = ($urandom_range(0, 63) == 0);
      s.clr   = ($urandom_range(0, 23) == 0);
      s.ev    = 8'($urandom);
      s.ev[3] = ($urandom_range(0, 15) == 0);
      s.rdReq = 1'($urandom_range(0, 1));
      s.rdSel = 3'($urandom_range(0, 7));
      applyStimulus(s, "rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
